truth_table_sweeper: RTL and testbench

//  Stimulus-and-capture stage for combinational boolean-function modules (fxy-style).

---
 rtl/truth_table_sweeper_pkg.sv | 13 +
 rtl/truth_table_sweeper_index_counter.sv | 30 +++
 rtl/truth_table_sweeper.sv | 134 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encodings and input-count limit.
package truth_table_sweeper_pkg;

    localparam int TT_MAX_N_IN = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

endpackage

// File: rtl/truth_table_sweeper_index_counter.sv
// Sweep index counter: one bit wider than the function input count so the last
// combination never wraps; exposes the low bits as the combination and a last flag.
module tt_index_counter #(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [N_IN-1:0] idx,
    output logic            last
);

    localparam logic [N_IN:0] LAST_IDX = {1'b0, {N_IN{1'b1}}};

    logic [N_IN:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (inc)
            cnt_q <= cnt_q + {{N_IN{1'b0}}, 1'b1};
    end

    assign idx  = cnt_q[N_IN-1:0];
    assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input combination onto vars, waits SETTLE cycles, samples f_in and
// builds the truth table in minterms. Optional TT_ONES_COUNT_EN adds a set-minterm count.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vars,
    output logic                 busy,
    output logic                 done,
`ifdef TT_ONES_COUNT_EN
    output logic [N_IN:0]        ones_cnt,
`endif
    output logic [2**N_IN-1:0]   minterms
);

    localparam logic [3:0] WAIT_INIT = 4'(SETTLE - 1);

    tt_state_e state_q, state_d;

    logic [N_IN-1:0]    idx;
    logic               idx_last;
    logic               idx_clr, idx_inc;
    logic               wait_load, wait_dec;
    logic               sample_en, tbl_clr;
    logic [3:0]         wait_q;
    logic [2**N_IN-1:0] minterms_q;

    tt_index_counter #(.N_IN(N_IN)) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (idx_clr),
        .inc  (idx_inc),
        .idx  (idx),
        .last (idx_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // abort outranks everything, including a simultaneous start
    always_comb begin
        state_d   = state_q;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        sample_en = 1'b0;
        tbl_clr   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            idx_clr = 1'b1;
            tbl_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d   = ST_DRIVE;
                        idx_clr   = 1'b1;
                        tbl_clr   = 1'b1;
                        wait_load = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (wait_q == 4'd0)
                        state_d = ST_SAMPLE;
                    else
                        wait_dec = 1'b1;
                end
                ST_SAMPLE: begin
                    sample_en = 1'b1;
                    if (idx_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_DRIVE;
                        idx_inc   = 1'b1;
                        wait_load = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_q <= 4'd0;
        else if (wait_load)
            wait_q <= WAIT_INIT;
        else if (wait_dec)
            wait_q <= wait_q - 4'd1;
    end

    // f_in is stored as-is, so an unknown output stays visible in the table
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            minterms_q <= '0;
        else if (tbl_clr)
            minterms_q <= '0;
        else if (sample_en)
            minterms_q[idx] <= f_in;
    end

`ifdef TT_ONES_COUNT_EN
    logic [N_IN:0] ones_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ones_q <= '0;
        else if (tbl_clr)
            ones_q <= '0;
        else if (sample_en && (f_in == 1'b1))
            ones_q <= ones_q + {{N_IN{1'b0}}, 1'b1};
    end

    assign ones_cnt = ones_q;
`endif

    assign vars     = idx;
    assign busy     = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done     = (state_q == ST_DONE);
    assign minterms = minterms_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: f = (x'+y)'.z sweep with SETTLE=1, plus an f=1 sweep with SETTLE=3.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, start_b, abort_b;
    logic [2:0] vars, vars_b;
    logic       busy, done, busy_b, done_b;
    logic [7:0] minterms, minterms_b;
    logic       f_in;
`ifdef TT_ONES_COUNT_EN
    logic [3:0] ones_cnt, ones_cnt_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // function under evaluation: x & ~y & z, true only for combination 5
    assign f_in = vars[2] & ~vars[1] & vars[0];

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .f_in     (f_in),
        .vars     (vars),
        .busy     (busy),
        .done     (done),
`ifdef TT_ONES_COUNT_EN
        .ones_cnt (ones_cnt),
`endif
        .minterms (minterms)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(3)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .abort    (abort_b),
        .f_in     (1'b1),
        .vars     (vars_b),
        .busy     (busy_b),
        .done     (done_b),
`ifdef TT_ONES_COUNT_EN
        .ones_cnt (ones_cnt_b),
`endif
        .minterms (minterms_b)
    );

    typedef struct {
        int         edge_n;
        logic [2:0] vars;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int k = 0; k <= 16; k++)
            tbl[k] = '{k, (k < 16) ? 3'(k / 2) : 3'd7, (k < 16), (k == 16)};

        rst = 1'b1; start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        #12;
        check("rst_vars", 32'(vars), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_minterms", 32'(minterms), 32'd0);
        check("rst_b_minterms", 32'(minterms_b), 32'd0);
`ifdef TT_ONES_COUNT_EN
        check("rst_ones", 32'(ones_cnt), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // full sweep, vars/busy/done after each edge
        start_a();
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) tick();
            check($sformatf("sweep_vars_e%0d", k), 32'(vars), 32'(tbl[k].vars));
            check($sformatf("sweep_busy_e%0d", k), 32'(busy), 32'(tbl[k].busy));
            check($sformatf("sweep_done_e%0d", k), 32'(done), 32'(tbl[k].done));
        end
        check("sweep_minterms", 32'(minterms), 32'h20);
`ifdef TT_ONES_COUNT_EN
        check("sweep_ones", 32'(ones_cnt), 32'd1);
`endif
        repeat (3) tick();
        check("hold_done", 32'(done), 32'd1);
        check("hold_vars", 32'(vars), 32'd7);
        check("hold_minterms", 32'(minterms), 32'h20);

        // abort sampled at edge 7
        start_a();
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_vars", 32'(vars), 32'd0);
        check("abort_minterms", 32'(minterms), 32'd0);
        tick();
        check("abort_idle", 32'(busy), 32'd0);
        start_a();
        repeat (16) tick();
        check("restart_done", 32'(done), 32'd1);
        check("restart_minterms", 32'(minterms), 32'h20);

        // start while busy is ignored: done still at edge 16
        start_a();
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("midstart_e15_done", 32'(done), 32'd0);
        check("midstart_e15_vars", 32'(vars), 32'd7);
        tick();
        check("midstart_e16_done", 32'(done), 32'd1);
        check("midstart_minterms", 32'(minterms), 32'h20);

        // start+abort from DONE -> IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_done_done", 32'(done), 32'd0);
        check("sa_done_busy", 32'(busy), 32'd0);
        check("sa_done_minterms", 32'(minterms), 32'd0);

        // start+abort mid-sweep -> IDLE
        start_a();
        repeat (4) tick();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_mid_busy", 32'(busy), 32'd0);
        check("sa_mid_vars", 32'(vars), 32'd0);
        tick();
        check("sa_mid_idle", 32'(busy), 32'd0);

        // async reset in SAMPLE of combination 6 (bit 5 already captured)
        start_a();
        repeat (13) tick();
        check("pre_rst_minterms", 32'(minterms), 32'h20);
        check("pre_rst_vars", 32'(vars), 32'd6);
        #2 rst = 1'b1;
        #1;
        check("arst_vars", 32'(vars), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_minterms", 32'(minterms), 32'd0);
`ifdef TT_ONES_COUNT_EN
        check("arst_ones", 32'(ones_cnt), 32'd0);
`endif
        #3 rst = 1'b0;
        tick();

        // f=1, SETTLE=3: four edges per combination
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (3) tick();
        check("b_e3_vars", 32'(vars_b), 32'd0);
        tick();
        check("b_e4_vars", 32'(vars_b), 32'd1);
        repeat (27) tick();
        check("b_e31_done", 32'(done_b), 32'd0);
        tick();
        check("b_e32_done", 32'(done_b), 32'd1);
        check("b_e32_busy", 32'(busy_b), 32'd0);
        check("b_minterms", 32'(minterms_b), 32'hFF);
`ifdef TT_ONES_COUNT_EN
        check("b_ones", 32'(ones_cnt_b), 32'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
